// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the memory-port arbiter.
//                Read-owner tag, halt FSM state encoding and the word-size
//                funct3 code used for fetch and debug accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Which port a read in flight belongs to.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_DBG   = 2'd3
  } owner_e;

  // Core-quiesce state machine.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage
`default_nettype wire

// File: rtl/mem_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_picker
//  Description : Two-way round-robin choice between the fetch and data ports.
//                On a conflict the port that did not win most recently is
//                picked. The pointer only moves when one of the two is picked.
//  Ports       : clk, rst          - clock / synchronous active-high reset
//                i_enable          - core grants permitted this cycle
//                i_fetch_req       - fetch port request
//                i_data_req        - data port request
//                o_fetch_pick      - fetch wins this cycle
//                o_data_pick       - data wins this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_picker (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_fetch_req,
  input  logic i_data_req,
  output logic o_fetch_pick,
  output logic o_data_pick
);

  // 1: data wins the next conflict, 0: fetch wins it.
  logic r_favor_data;

  always_comb begin
    o_fetch_pick = 1'b0;
    o_data_pick  = 1'b0;
    if (i_enable) begin
      if (i_fetch_req && i_data_req) begin
        o_data_pick  = r_favor_data;
        o_fetch_pick = ~r_favor_data;
      end else begin
        o_fetch_pick = i_fetch_req;
        o_data_pick  = i_data_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_favor_data <= 1'b1;
    end else if (o_fetch_pick) begin
      r_favor_data <= 1'b1;
    end else if (o_data_pick) begin
      r_favor_data <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Arbitrates instruction fetch, load/store and debug ports onto
//                one shared memory port. Debug has absolute priority; fetch
//                and data share round-robin. Grants are combinational, reads
//                return one cycle later to the registered owner. A halt FSM
//                (RUN/DRAIN/HALTED) blocks core traffic for the debugger.
//  Ports       : clk, reset                  - clock / sync active-high reset
//                fetch_*                     - instruction fetch read port
//                data_*                      - core load/store port
//                dbg_*                       - debug/loader word port
//                dbg_halt_req / dbg_halt_ack - core-quiesce handshake
//                mem_*                       - shared memory port
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [2:0]  data_funct3,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  // debug port
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  input  logic        dbg_halt_req,
  output logic        dbg_halt_ack,
  // shared memory port
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  state_e r_state;
  state_e w_state_next;
  owner_e r_owner;
  owner_e w_owner_next;

  logic w_core_allowed;
  logic w_halt_ack;
  logic w_core_pending;
  logic w_core_en;
  logic w_fetch_pick;
  logic w_data_pick;
  logic w_dbg_gnt;

  // Only core reads matter for quiescing; debug traffic may continue.
  assign w_core_pending = (r_owner == OWN_FETCH) || (r_owner == OWN_DATA);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (dbg_halt_req) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!dbg_halt_req)       w_state_next = ST_RUN;
        else if (!w_core_pending) w_state_next = ST_HALTED;
      end
      ST_HALTED: begin
        if (!dbg_halt_req) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_core_allowed = 1'b0;
    w_halt_ack     = 1'b0;
    case (r_state)
      ST_RUN:    w_core_allowed = 1'b1;
      ST_HALTED: w_halt_ack     = 1'b1;
      default: begin
        w_core_allowed = 1'b0;
        w_halt_ack     = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------- arbitration
  // A raised halt request blocks new core grants at once, so DRAIN only ever
  // waits for reads that were already in flight. Reset masks every grant.
  assign w_dbg_gnt = ~reset & dbg_req;
  assign w_core_en = ~reset & ~dbg_req & ~dbg_halt_req & w_core_allowed;

  mem_rr_picker u_rr_picker (
    .clk          (clk),
    .rst          (reset),
    .i_enable     (w_core_en),
    .i_fetch_req  (fetch_req),
    .i_data_req   (data_req),
    .o_fetch_pick (w_fetch_pick),
    .o_data_pick  (w_data_pick)
  );

  assign fetch_gnt = w_fetch_pick;
  assign data_gnt  = w_data_pick;
  assign dbg_gnt   = w_dbg_gnt;

  // ----------------------------------------------------- memory port mux
  always_comb begin
    mem_write         = 1'b0;
    mem_funct3        = 3'b000;
    mem_write_address = 32'd0;
    mem_write_data    = 32'd0;
    mem_read_address  = 32'd0;
    if (w_dbg_gnt) begin
      mem_write         = dbg_we;
      mem_funct3        = FUNCT3_WORD;
      mem_write_address = dbg_addr;
      mem_read_address  = dbg_addr;
      mem_write_data    = dbg_wdata;
    end else if (w_data_pick) begin
      mem_write         = data_we;
      mem_funct3        = data_funct3;
      mem_write_address = data_addr;
      mem_read_address  = data_addr;
      mem_write_data    = data_wdata;
    end else if (w_fetch_pick) begin
      mem_funct3        = FUNCT3_WORD;
      mem_write_address = fetch_addr;
      mem_read_address  = fetch_addr;
    end
  end

  // ------------------------------------------------------ read return
  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_dbg_gnt && !dbg_we)         w_owner_next = OWN_DBG;
    else if (w_data_pick && !data_we) w_owner_next = OWN_DATA;
    else if (w_fetch_pick)            w_owner_next = OWN_FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  // Masking with reset keeps a read that was in flight when reset arrived
  // from surfacing during the reset cycle itself.
  assign fetch_rvalid = ~reset & (r_owner == OWN_FETCH);
  assign data_rvalid  = ~reset & (r_owner == OWN_DATA);
  assign dbg_rvalid   = ~reset & (r_owner == OWN_DBG);

  assign fetch_rdata  = fetch_rvalid ? mem_read_data : 32'd0;
  assign data_rdata   = data_rvalid  ? mem_read_data : 32'd0;
  assign dbg_rdata    = dbg_rvalid   ? mem_read_data : 32'd0;

  assign dbg_halt_ack = ~reset & w_halt_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A driver applies
//                directed and random stimulus, predicts grants and memory
//                port values from a behavioural model and queues expected
//                read returns; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt, fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        data_req, data_we;
  logic [31:0] data_addr, data_wdata;
  logic [2:0]  data_funct3;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_halt_req, dbg_halt_ack;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address, mem_write_data, mem_read_address;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_req         (fetch_req),
    .fetch_addr        (fetch_addr),
    .fetch_gnt         (fetch_gnt),
    .fetch_rvalid      (fetch_rvalid),
    .fetch_rdata       (fetch_rdata),
    .data_req          (data_req),
    .data_we           (data_we),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_funct3       (data_funct3),
    .data_gnt          (data_gnt),
    .data_rvalid       (data_rvalid),
    .data_rdata        (data_rdata),
    .dbg_req           (dbg_req),
    .dbg_we            (dbg_we),
    .dbg_addr          (dbg_addr),
    .dbg_wdata         (dbg_wdata),
    .dbg_gnt           (dbg_gnt),
    .dbg_rvalid        (dbg_rvalid),
    .dbg_rdata         (dbg_rdata),
    .dbg_halt_req      (dbg_halt_req),
    .dbg_halt_ack      (dbg_halt_ack),
    .mem_write         (mem_write),
    .mem_funct3        (mem_funct3),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data)
  );

  // Expected read return: owner 1=fetch 2=data 3=dbg, due = cycle number.
  typedef struct {
    int          owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit running  = 1'b0;

  // Behavioural model: mode 0=run 1=drain 2=halted.
  int m_mode        = 0;
  bit m_favor_data  = 1'b1;
  bit m_core_out    = 1'b0;

  // Memory: a few preloaded words, everything else a hash of the address.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] cap_addr = 32'd0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  always @(posedge clk) cap_addr <= mem_read_address;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic set_idle();
    reset = 1'b0; fetch_req = 1'b0; fetch_addr = 32'd0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'd0; data_wdata = 32'd0;
    data_funct3 = 3'd0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0;
    dbg_wdata = 32'd0; dbg_halt_req = 1'b0;
  endtask

  // One clock cycle: called just after a rising edge with inputs applied.
  task automatic do_cycle();
    int          g;
    bit          eack, core_ok;
    logic        ewe;
    logic [2:0]  ef3;
    logic [31:0] ea, ewd;
    mem_read_data = rd(cap_addr);
    #1;
    g = 0; eack = 1'b0;
    if (reset) begin
      q.delete();
    end else begin
      eack    = (m_mode == 2);
      core_ok = (m_mode == 0) && !dbg_halt_req;
      if (dbg_req) g = 3;
      else if (core_ok) begin
        if (fetch_req && data_req) g = m_favor_data ? 2 : 1;
        else if (fetch_req)        g = 1;
        else if (data_req)         g = 2;
      end
    end
    ewe = 1'b0; ef3 = 3'd0; ea = 32'd0; ewd = 32'd0;
    case (g)
      1: begin ea = fetch_addr; ef3 = 3'b010; end
      2: begin ea = data_addr; ewd = data_wdata; ewe = data_we; ef3 = data_funct3; end
      3: begin ea = dbg_addr; ewd = dbg_wdata; ewe = dbg_we; ef3 = 3'b010; end
      default: ;
    endcase
    chk("fetch_gnt", {31'd0, fetch_gnt}, {31'd0, g == 1});
    chk("data_gnt",  {31'd0, data_gnt},  {31'd0, g == 2});
    chk("dbg_gnt",   {31'd0, dbg_gnt},   {31'd0, g == 3});
    chk("mem_write", {31'd0, mem_write}, {31'd0, ewe});
    chk("mem_funct3", {29'd0, mem_funct3}, {29'd0, ef3});
    chk("mem_write_address", mem_write_address, ea);
    chk("mem_read_address",  mem_read_address,  ea);
    chk("mem_write_data",    mem_write_data,    ewd);
    chk("dbg_halt_ack", {31'd0, dbg_halt_ack}, {31'd0, eack});
    if (g != 0 && !ewe) q.push_back('{g, rd(ea), cyc + 1});
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_mode = 0; m_favor_data = 1'b1; m_core_out = 1'b0;
    end else begin
      if (g == 1)      m_favor_data = 1'b1;
      else if (g == 2) m_favor_data = 1'b0;
      case (m_mode)
        0: if (dbg_halt_req) m_mode = 1;
        1: if (!dbg_halt_req) m_mode = 0; else if (!m_core_out) m_mode = 2;
        default: if (!dbg_halt_req) m_mode = 0;
      endcase
      m_core_out = (g == 1 || g == 2) && !ewe;
    end
    #1;
  endtask

  // Monitor: compares read returns against the scoreboard queue.
  int   mon_n;
  int   mon_own;
  exp_t mon_e;
  always @(negedge clk) begin
    if (running) begin
      mon_n   = int'(fetch_rvalid) + int'(data_rvalid) + int'(dbg_rvalid);
      mon_own = fetch_rvalid ? 1 : (data_rvalid ? 2 : (dbg_rvalid ? 3 : 0));
      if (!fetch_rvalid) chk("fetch_rdata_idle", fetch_rdata, 32'd0);
      if (!data_rvalid)  chk("data_rdata_idle",  data_rdata,  32'd0);
      if (!dbg_rvalid)   chk("dbg_rdata_idle",   dbg_rdata,   32'd0);
      if (mon_n > 1) chk("rvalid_onehot", mon_n, 1);
      if (mon_n >= 1) begin
        if (q.size() == 0) begin
          chk("rvalid_unexpected_owner", mon_own, 0);
        end else begin
          mon_e = q.pop_front();
          chk("rvalid_owner", mon_own, mon_e.owner);
          chk("rvalid_cycle", cyc, mon_e.due);
          case (mon_own)
            1: chk("fetch_rdata", fetch_rdata, mon_e.data);
            2: chk("data_rdata",  data_rdata,  mon_e.data);
            default: chk("dbg_rdata", dbg_rdata, mon_e.data);
          endcase
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        mon_e = q.pop_front();
        chk("rvalid_missing_owner", 0, mon_e.owner);
      end
    end
  end

  initial begin
    mem[32'h40] = 32'h00500093;
    set_idle();
    running = 1'b1;
    reset = 1'b1;
    do_cycle(); do_cycle();
    reset = 1'b0;
    do_cycle();

    // single fetch read
    fetch_req = 1'b1; fetch_addr = 32'h40;
    do_cycle();
    set_idle(); do_cycle();

    // fetch/data conflict right after reset: data, fetch, data, fetch
    reset = 1'b1; do_cycle(); reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h200;
    data_req = 1'b1; data_addr = 32'h300; data_funct3 = 3'b010;
    repeat (4) do_cycle();
    set_idle(); do_cycle();

    // debug beats everyone, word write
    fetch_req = 1'b1; data_req = 1'b1; dbg_req = 1'b1;
    dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'hDEADBEEF;
    do_cycle();
    set_idle(); do_cycle();

    // halt handshake around an in-flight data read
    data_req = 1'b1; data_addr = 32'h44; data_funct3 = 3'b100;
    do_cycle();
    data_req = 1'b0; dbg_halt_req = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h48;
    repeat (4) do_cycle();
    dbg_halt_req = 1'b0;
    do_cycle(); do_cycle();
    set_idle(); do_cycle();

    // reset the cycle after a fetch grant
    fetch_req = 1'b1; fetch_addr = 32'h40;
    do_cycle();
    reset = 1'b1;
    do_cycle();
    set_idle(); do_cycle(); do_cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(63) == 0);
      fetch_req   = ($urandom_range(99) < 60);
      fetch_addr  = {$urandom_range(255), 2'b00};
      data_req    = ($urandom_range(99) < 55);
      data_we     = $urandom_range(1);
      data_addr   = $urandom;
      data_wdata  = $urandom;
      data_funct3 = 3'($urandom_range(7));
      dbg_req     = ($urandom_range(99) < 20);
      dbg_we      = $urandom_range(1);
      dbg_addr    = $urandom;
      dbg_wdata   = $urandom;
      if ($urandom_range(19) == 0) dbg_halt_req = ~dbg_halt_req;
      do_cycle();
    end

    set_idle();
    repeat (3) do_cycle();
    chk("queue_empty_at_end", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
